msg_serializer: RTL
===================

Name: msg_serializer

Overview:
- Transmit-side counterpart of the message parser. Accepts one whole message per handshake: parallel data, byte length and error flag.
- Emits the message as an AXI-Stream master beat sequence, LSB byte first, with tkeep, tlast and tuser (error on tlast).
- Sits between message producers and any AXI-ST slave, including the message parser for loopback.

Parameters:
- MAX_MSG_BYTES, 32: capacity of the message buffer in bytes.
- DATA_BYTES, 8: AXI-ST data width in bytes.
- TKEEP_WIDTH, 8: tkeep width; must equal DATA_BYTES.
- Derived localparam MAX_BEATS = ceil(MAX_MSG_BYTES/DATA_BYTES).

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- msg_valid  in  1  message offered
- msg_ready  out  1  message accepted when msg_valid && msg_ready
- msg_length  in  16  message length in bytes
- msg_data  in  8*MAX_MSG_BYTES  message bytes, byte 0 on [7:0]
- msg_error  in  1  message carries error; reported on m_tuser of last beat
- msg_drop  out  1  one-cycle pulse: zero-length message discarded
- m_tvalid  out  1  AXI-ST valid
- m_tready  in  1  AXI-ST ready
- m_tlast  out  1  final beat of message
- m_tdata  out  8*DATA_BYTES  beat data
- m_tkeep  out  TKEEP_WIDTH  byte enables
- m_tuser  out  1  error flag, valid only with m_tlast

Behaviour:
- Reset (rst low, asynchronous): state IDLE, msg_ready=0 during reset, m_tvalid=0, m_tlast=0, m_tdata=0, m_tkeep=0, m_tuser=0, msg_drop=0, beat counter=0.
- msg_ready=1 in IDLE from the first clock after reset release.
- States:
  - IDLE to SEND on an accepted message with msg_length != 0.
  - SEND to IDLE on the final-beat handshake, unless a new message is accepted in the same cycle.
- Accept: capture msg_data, effective length and msg_error into the buffer. Counter cleared.
- Length rules:
  - len = min(msg_length, MAX_MSG_BYTES).
  - If msg_length > MAX_MSG_BYTES, the message is truncated and the stored error is forced to 1.
- Zero length: accepted and discarded, no beats, msg_drop=1 for the following cycle, state stays IDLE.
- Beat count: N = ceil(len/DATA_BYTES). Beat k carries buffer bytes k*DATA_BYTES .. k*DATA_BYTES+DATA_BYTES-1.
- tkeep:
  - All ones on every beat except the last.
  - Last beat: (1<<r)-1 where r = len mod DATA_BYTES, or all ones if r=0.
  - Bytes with tkeep=0 drive 0 on m_tdata.
- m_tlast=1 only on beat N-1. m_tuser equals the stored error on the last beat and is 0 on all other beats.
- Latency: message accepted at edge T, so beat 0 is valid from T+1 (registered outputs).
- Beat advance occurs only on m_tvalid && m_tready; one beat per cycle under continuous ready.
- AXI rule: once m_tvalid=1, m_tvalid, m_tdata, m_tkeep, m_tlast and m_tuser hold stable until the handshake. m_tvalid never depends combinationally on m_tready.
- Back-to-back: msg_ready=1 in SEND during the cycle in which the last beat handshakes (m_tvalid && m_tready && m_tlast). A message accepted then presents its beat 0 on the next cycle with no bubble.
- msg_ready=0 in SEND at all other times; msg_data may change freely after acceptance.
- Reset mid-message: outputs return to reset values immediately. The partial message is lost and not resumed.

Decomposition:
- Package msg_pkg holds:
  - state enum {IDLE, SEND};
  - function keep_mask(r, width) returning the tkeep mask;
  - function num_beats(len).
- Sub-module msg_beat_counter: counts beats 0..N-1, takes load/advance inputs, outputs index and is_last.

Test Plan:
- len=20, data bytes 0x00..0x13, m_tready=1: 3 beats at T+1..T+3. tkeep FF/FF/0F; tlast on beat 2 only; beat 2 tdata = 0x00000000_13121110.
- len=16, msg_error=1: 2 beats, tkeep FF/FF, tuser=1 only on beat 1 with tlast.
- len=20 with m_tready toggled 1,0,0,1,...: m_tvalid and all payload signals hold stable during stalls; exactly 3 handshakes; no beat lost or duplicated.
- Two messages (len=8, then len=12) offered continuously: msg_ready high in the last-beat cycle. Beats are single FF/last; then FF, 0F/last, with no idle cycle between.
- msg_length=0: no m_tvalid; msg_drop pulses once; msg_ready stays 1. msg_length=40: 4 beats of FF, tlast on beat 3, tuser=1.
- Assert rst low during beat 1 of a 3-beat message: m_tvalid=0 asynchronously. After release, the next len=8 message emits a single correct beat.

Source files
------------

// File: rtl/msg_serializer_pkg.sv
// Shared types and helpers for the message serializer: FSM states,
// last-beat byte-enable mask and beat count from a byte length.
package msg_pkg;

   typedef enum logic [0:0] {IDLE, SEND} state_t;

   localparam int KEEP_MAX = 64;

   function automatic logic [KEEP_MAX-1:0] keep_mask(input int unsigned r, input int unsigned width);
      logic [KEEP_MAX-1:0] m;
      m = '0;
      // A remainder of zero means the last beat is completely full
      for (int unsigned i = 0; i < KEEP_MAX; i++) begin
         if (i < width && (r == 0 || i < r)) begin
            m[i] = 1'b1;
         end
      end
      return m;
   endfunction

   function automatic int unsigned num_beats(input int unsigned len, input int unsigned dataBytes);
      return (len + dataBytes - 1) / dataBytes;
   endfunction

endpackage

// File: rtl/msg_serializer_if.sv
// Handshake bundles around the serializer: whole-message request side
// and the AXI-Stream beat side.
interface msg_req_if #(parameter int MAX_MSG_BYTES = 32) ();
   logic                         msg_valid;
   logic                         msg_ready;
   logic [15:0]                  msg_length;
   logic [8*MAX_MSG_BYTES-1:0]   msg_data;
   logic                         msg_error;
   logic                         msg_drop;

   modport master (output msg_valid, msg_length, msg_data, msg_error,
                   input  msg_ready, msg_drop);
   modport slave  (input  msg_valid, msg_length, msg_data, msg_error,
                   output msg_ready, msg_drop);
endinterface

interface axis_if #(parameter int DATA_BYTES = 8, parameter int TKEEP_WIDTH = 8) ();
   logic                      m_tvalid;
   logic                      m_tready;
   logic                      m_tlast;
   logic [8*DATA_BYTES-1:0]   m_tdata;
   logic [TKEEP_WIDTH-1:0]    m_tkeep;
   logic                      m_tuser;

   modport master (output m_tvalid, m_tlast, m_tdata, m_tkeep, m_tuser,
                   input  m_tready);
   modport slave  (input  m_tvalid, m_tlast, m_tdata, m_tkeep, m_tuser,
                   output m_tready);
endinterface

// File: rtl/msg_serializer_beat_counter.sv
// Beat index within the current message; load starts a new message at
// beat 0 and remembers which index is the final one.
module msg_beat_counter #(
   parameter int MAX_BEATS = 4,
   parameter int CW        = $clog2(MAX_BEATS + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_i,
   input  logic [CW-1:0] beats_i,
   input  logic          advance_i,
   output logic [CW-1:0] index_o,
   output logic          is_last_o
);

   logic [CW-1:0] idx_q, idx_d;
   logic [CW-1:0] lastIdx_q, lastIdx_d;

   assign index_o   = idx_q;
   assign is_last_o = (idx_q == lastIdx_q);

   // A load wins over an advance so a back-to-back message restarts at beat 0
   always_comb begin
      idx_d     = idx_q;
      lastIdx_d = lastIdx_q;
      if (load_i) begin
         idx_d     = '0;
         lastIdx_d = beats_i - CW'(1);
      end else if (advance_i && !is_last_o) begin
         idx_d = idx_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q     <= '0;
         lastIdx_q <= '0;
      end else begin
         idx_q     <= idx_d;
         lastIdx_q <= lastIdx_d;
      end
   end

endmodule

// File: rtl/msg_serializer.sv
// Buffers one whole message and replays it as AXI-Stream beats, LSB byte
// first, with the error flag reported on the last beat.
module msg_serializer
   import msg_pkg::*;
#(
   parameter int MAX_MSG_BYTES = 32,
   parameter int DATA_BYTES    = 8,
   parameter int TKEEP_WIDTH   = 8
) (
   input  logic       clk,
   input  logic       rst,
   msg_req_if.slave   req,
   axis_if.master     axis
);

   localparam int MAX_BEATS = (MAX_MSG_BYTES + DATA_BYTES - 1) / DATA_BYTES;
   localparam int BEAT_W    = 8 * DATA_BYTES;
   localparam int BUF_W     = BEAT_W * MAX_BEATS;
   localparam int MSG_W     = 8 * MAX_MSG_BYTES;
   localparam int CW        = $clog2(MAX_BEATS + 1);

   state_t            state_q, state_d;
   logic [BUF_W-1:0]  buf_q, buf_d;
   logic [15:0]       len_q, len_d;
   logic              err_q, err_d;
   logic              readyEn_q;
   logic              drop_q;

   logic              trunc;
   logic              nonZero;
   logic [15:0]       effLen;
   logic              accept;
   logic              handshake;
   logic              hsLast;
   logic              isLast;
   logic [CW-1:0]     beatIdx;
   logic [CW-1:0]     loadBeats;
   logic [BEAT_W-1:0] beatData;
   logic [TKEEP_WIDTH-1:0] lastKeep;
   logic [TKEEP_WIDTH-1:0] keepOut;

   assign trunc     = req.msg_length > 16'(MAX_MSG_BYTES);
   assign nonZero   = req.msg_length != '0;
   assign effLen    = trunc ? 16'(MAX_MSG_BYTES) : req.msg_length;
   assign handshake = axis.m_tvalid && axis.m_tready;
   assign hsLast    = handshake && isLast;
   assign accept    = req.msg_valid && req.msg_ready;
   assign loadBeats = CW'(num_beats(32'(effLen), DATA_BYTES));

   // Ready only opens in SEND while the final beat is handing off
   assign req.msg_ready = readyEn_q && ((state_q == IDLE) || hsLast);
   assign req.msg_drop  = drop_q;

   msg_beat_counter #(.MAX_BEATS(MAX_BEATS), .CW(CW)) u_counter (
      .clk       (clk),
      .rst       (rst),
      .load_i    (accept && nonZero),
      .beats_i   (loadBeats),
      .advance_i (handshake),
      .index_o   (beatIdx),
      .is_last_o (isLast)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept && nonZero) state_d = SEND;
         SEND: if (hsLast) state_d = (accept && nonZero) ? SEND : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Oversized messages keep their first MAX_MSG_BYTES and are flagged bad
   always_comb begin
      buf_d = buf_q;
      len_d = len_q;
      err_d = err_q;
      if (accept) begin
         buf_d              = '0;
         buf_d[MSG_W-1:0]   = req.msg_data;
         len_d              = effLen;
         err_d              = req.msg_error || trunc;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_q     <= '0;
         len_q     <= '0;
         err_q     <= 1'b0;
         readyEn_q <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         buf_q     <= buf_d;
         len_q     <= len_d;
         err_q     <= err_d;
         readyEn_q <= 1'b1;
         drop_q    <= accept && !nonZero;
      end
   end

   assign beatData = buf_q[int'(beatIdx) * BEAT_W +: BEAT_W];
   assign lastKeep = TKEEP_WIDTH'(keep_mask(32'(len_q) % DATA_BYTES, DATA_BYTES));

   // Outputs depend only on flops, so they hold steady through any stall
   always_comb begin
      axis.m_tvalid = 1'b0;
      axis.m_tlast  = 1'b0;
      axis.m_tuser  = 1'b0;
      axis.m_tkeep  = '0;
      axis.m_tdata  = '0;
      keepOut       = '0;
      if (state_q == SEND) begin
         keepOut       = isLast ? lastKeep : '1;
         axis.m_tvalid = 1'b1;
         axis.m_tlast  = isLast;
         axis.m_tuser  = isLast && err_q;
         axis.m_tkeep  = keepOut;
         for (int b = 0; b < DATA_BYTES; b++) begin
            axis.m_tdata[b*8 +: 8] = keepOut[b] ? beatData[b*8 +: 8] : 8'h00;
         end
      end
   end

endmodule
